// File: rtl/crc_frame_arbiter.sv
// crc_frame_arbiter
// Two 64-bit AXI-Stream frame sources share one crc_mac. Frames are granted
// whole, in round-robin order. Each grant pushes its source ID into a small
// FIFO. On the return path the FIFO head tags the crc_mac output stream, and
// one CRC result record is produced per frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame in progress; arbitrate when the ID FIFO has room
// BUSY  | forwarding the granted source's frame to crc_mac until tlast

module crc_frame_arbiter #(
    parameter int ID_FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        aresetn,

    input  logic [63:0] s0_axis_tdata,
    input  logic [7:0]  s0_axis_tkeep,
    input  logic        s0_axis_tlast,
    input  logic        s0_axis_tuser,
    input  logic        s0_axis_tvalid,
    output logic        s0_axis_tready,

    input  logic [63:0] s1_axis_tdata,
    input  logic [7:0]  s1_axis_tkeep,
    input  logic        s1_axis_tlast,
    input  logic        s1_axis_tuser,
    input  logic        s1_axis_tvalid,
    output logic        s1_axis_tready,

    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,

    input  logic [63:0] c_axis_tdata,
    input  logic [7:0]  c_axis_tkeep,
    input  logic        c_axis_tlast,
    input  logic        c_axis_tuser,
    input  logic        c_axis_tvalid,
    output logic        c_axis_tready,
    input  logic [31:0] crc_in,

    output logic [63:0] o_axis_tdata,
    output logic [7:0]  o_axis_tkeep,
    output logic        o_axis_tlast,
    output logic        o_axis_tuser,
    output logic        o_axis_tvalid,
    input  logic        o_axis_tready,
    output logic        o_axis_tdest,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_crc,
    output logic        res_src,
    output logic        res_tuser,
    output logic        err_underflow
);

    localparam int AW = $clog2(ID_FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic grant, grant_nxt;
    logic last_grant, last_grant_nxt;

    logic [ID_FIFO_DEPTH-1:0] id_mem;
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              id_count;
    logic                     id_full, id_empty, id_head;
    logic                     id_push, id_pop;

    logic stall, c_last_hs;

    assign id_full  = (id_count == (AW+1)'(ID_FIFO_DEPTH));
    assign id_empty = (id_count == '0);
    assign id_head  = id_mem[rd_ptr];

    // Arbitration and input mux; payload always follows grant, tvalid/tready only in BUSY.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        id_push        = 1'b0;
        m_axis_tdata   = grant ? s1_axis_tdata : s0_axis_tdata;
        m_axis_tkeep   = grant ? s1_axis_tkeep : s0_axis_tkeep;
        m_axis_tlast   = grant ? s1_axis_tlast : s0_axis_tlast;
        m_axis_tuser   = grant ? s1_axis_tuser : s0_axis_tuser;
        m_axis_tvalid  = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                if ((s0_axis_tvalid || s1_axis_tvalid) && !id_full) begin
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        grant_nxt = ~last_grant;
                    end else begin
                        grant_nxt = s1_axis_tvalid;
                    end
                    last_grant_nxt = grant_nxt;
                    id_push        = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            BUSY: begin
                m_axis_tvalid  = grant ? s1_axis_tvalid : s0_axis_tvalid;
                s0_axis_tready = !grant && m_axis_tready;
                s1_axis_tready = grant && m_axis_tready;
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, grant and round-robin history registers.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Return path: the only added backpressure holds a tlast beat while an unread record is pending.
    assign stall         = c_axis_tlast & res_valid & ~res_ready;
    assign c_axis_tready = o_axis_tready & ~stall;
    assign o_axis_tvalid = c_axis_tvalid & ~stall;
    assign o_axis_tdata  = c_axis_tdata;
    assign o_axis_tkeep  = c_axis_tkeep;
    assign o_axis_tlast  = c_axis_tlast;
    assign o_axis_tuser  = c_axis_tuser;
    assign o_axis_tdest  = id_empty ? 1'b0 : id_head;

    assign c_last_hs = c_axis_tvalid & c_axis_tready & c_axis_tlast;
    assign id_pop    = c_last_hs & ~id_empty;

    // Source-ID FIFO: push on grant, pop on each returned tlast.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            id_mem   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            id_count <= '0;
        end else begin
            if (id_push) begin
                id_mem[wr_ptr] <= grant_nxt;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (id_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            id_count <= id_count + {{AW{1'b0}}, id_push} - {{AW{1'b0}}, id_pop};
        end
    end

    // Result record and sticky underflow flag; a reload in the same cycle wins over the clear.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            res_valid     <= 1'b0;
            res_crc       <= '0;
            res_src       <= 1'b0;
            res_tuser     <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (c_last_hs) begin
                res_valid <= 1'b1;
                res_crc   <= crc_in;
                res_src   <= id_empty ? 1'b0 : id_head;
                res_tuser <= c_axis_tuser;
                if (id_empty) begin
                    err_underflow <= 1'b1;
                end
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_arbiter.sv
module tb_crc_frame_arbiter;

    logic        clock;
    logic        aresetn;

    logic [63:0] s_tdata[2];
    logic [7:0]  s_tkeep[2];
    logic        s_tlast[2];
    logic        s_tuser[2];
    logic        s_tvalid[2];
    logic        s_tready_w[2];
    logic        s0_axis_tready, s1_axis_tready;

    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready;

    logic [63:0] c_axis_tdata;
    logic [7:0]  c_axis_tkeep;
    logic        c_axis_tlast, c_axis_tuser, c_axis_tvalid, c_axis_tready;
    logic [31:0] crc_in;

    logic [63:0] o_axis_tdata;
    logic [7:0]  o_axis_tkeep;
    logic        o_axis_tlast, o_axis_tuser, o_axis_tvalid, o_axis_tready, o_axis_tdest;

    logic        res_valid, res_ready, res_src, res_tuser, err_underflow;
    logic [31:0] res_crc;

    assign s_tready_w[0] = s0_axis_tready;
    assign s_tready_w[1] = s1_axis_tready;

    crc_frame_arbiter #(.ID_FIFO_DEPTH(4)) dut (
        .clock(clock), .aresetn(aresetn),
        .s0_axis_tdata(s_tdata[0]), .s0_axis_tkeep(s_tkeep[0]), .s0_axis_tlast(s_tlast[0]),
        .s0_axis_tuser(s_tuser[0]), .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s_tdata[1]), .s1_axis_tkeep(s_tkeep[1]), .s1_axis_tlast(s_tlast[1]),
        .s1_axis_tuser(s_tuser[1]), .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .c_axis_tdata(c_axis_tdata), .c_axis_tkeep(c_axis_tkeep), .c_axis_tlast(c_axis_tlast),
        .c_axis_tuser(c_axis_tuser), .c_axis_tvalid(c_axis_tvalid), .c_axis_tready(c_axis_tready),
        .crc_in(crc_in),
        .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep), .o_axis_tlast(o_axis_tlast),
        .o_axis_tuser(o_axis_tuser), .o_axis_tvalid(o_axis_tvalid), .o_axis_tready(o_axis_tready),
        .o_axis_tdest(o_axis_tdest),
        .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc), .res_src(res_src),
        .res_tuser(res_tuser), .err_underflow(err_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] crc;
        logic        src;
        logic        tuser;
    } rec_t;

    rec_t sb_q[$];
    logic tdest_q[$];
    int   order_q[$];
    rec_t mon_e;
    int   recs_seen = 0;
    int   frames_done = 0;
    int   drive_cyc[2];
    int   first_hs_cyc[2];
    int   last_end_cyc = 0;
    logic have_end = 1'b0;
    logic gap_chk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_beat(input logic [31:0] c, input logic [63:0] d, input logic [7:0] k);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                r = r ^ {24'd0, d[8*i +: 8]};
                for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] seed, input int b);
        return seed ^ (64'(b + 1) * 64'h9E3779B97F4A7C15);
    endfunction

    // Stand-in for crc_mac: buffers accepted beats and computes CRC32 per frame.
    logic        inj_en, inj_valid, inj_user;
    logic [31:0] inj_crc;
    logic        mdl_ready;
    logic [63:0] mb_data[64];
    logic [7:0]  mb_keep[64];
    logic        mb_last[64];
    logic        mb_user[64];
    logic [31:0] fcrc[64];
    logic [5:0]  mb_wr, mb_rd, fw, fr;
    logic [31:0] run_crc;

    assign m_axis_tready = mdl_ready;

    always @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            mb_wr   <= '0;
            mb_rd   <= '0;
            fw      <= '0;
            fr      <= '0;
            run_crc <= 32'hFFFFFFFF;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                mb_data[mb_wr] <= m_axis_tdata;
                mb_keep[mb_wr] <= m_axis_tkeep;
                mb_last[mb_wr] <= m_axis_tlast;
                mb_user[mb_wr] <= m_axis_tuser;
                mb_wr          <= mb_wr + 6'd1;
                if (m_axis_tlast) begin
                    fcrc[fw] <= ~crc_beat(run_crc, m_axis_tdata, m_axis_tkeep);
                    fw       <= fw + 6'd1;
                    run_crc  <= 32'hFFFFFFFF;
                end else begin
                    run_crc <= crc_beat(run_crc, m_axis_tdata, m_axis_tkeep);
                end
            end
            if (!inj_en && c_axis_tvalid && c_axis_tready) begin
                mb_rd <= mb_rd + 6'd1;
                if (c_axis_tlast) fr <= fr + 6'd1;
            end
        end
    end

    always_comb begin
        c_axis_tvalid = 1'b0;
        c_axis_tdata  = '0;
        c_axis_tkeep  = '0;
        c_axis_tlast  = 1'b0;
        c_axis_tuser  = 1'b0;
        crc_in        = '0;
        if (inj_en) begin
            c_axis_tvalid = inj_valid;
            c_axis_tdata  = 64'h0BAD_F00D_0BAD_F00D;
            c_axis_tkeep  = 8'hFF;
            c_axis_tlast  = 1'b1;
            c_axis_tuser  = inj_user;
            crc_in        = inj_crc;
        end else begin
            c_axis_tvalid = (mb_wr != mb_rd);
            c_axis_tdata  = mb_data[mb_rd];
            c_axis_tkeep  = mb_keep[mb_rd];
            c_axis_tlast  = mb_last[mb_rd];
            c_axis_tuser  = mb_user[mb_rd];
            crc_in        = fcrc[fr];
        end
    end

    // Result scoreboard consumer.
    always @(negedge clock) begin
        if (aresetn && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("res_unexpected", 64'(res_valid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("res_crc", 64'(res_crc), 64'(mon_e.crc));
                check("res_src", 64'(res_src), 64'(mon_e.src));
                check("res_tuser", 64'(res_tuser), 64'(mon_e.tuser));
                recs_seen++;
            end
        end
    end

    // Tagged pass-through monitor.
    always @(negedge clock) begin
        if (aresetn && !inj_en && o_axis_tvalid && o_axis_tready) begin
            check("o_tdata", o_axis_tdata, mb_data[mb_rd]);
            check("o_tkeep", 64'(o_axis_tkeep), 64'(mb_keep[mb_rd]));
            check("o_tuser", 64'(o_axis_tuser), 64'(mb_user[mb_rd]));
            if (tdest_q.size() == 0) begin
                check("o_unexpected", 64'(o_axis_tvalid), 64'd0);
            end else begin
                check("o_tdest", 64'(o_axis_tdest), 64'(tdest_q[0]));
                if (o_axis_tlast) void'(tdest_q.pop_front());
            end
        end
    end

    task automatic send_frame(input int src, input int nb, input logic [7:0] klast, input logic tu,
                              input logic [63:0] seed, input logic e_src, input logic e_tu);
        logic [31:0] crc;
        crc = 32'hFFFFFFFF;
        for (int b = 0; b < nb; b++) begin
            int budget;
            logic [63:0] d;
            logic [7:0]  k;
            d = beat_data(seed, b);
            k = (b == nb - 1) ? klast : 8'hFF;
            s_tdata[src]  = d;
            s_tkeep[src]  = k;
            s_tlast[src]  = (b == nb - 1);
            s_tuser[src]  = (b == nb - 1) ? tu : 1'b0;
            s_tvalid[src] = 1'b1;
            if (b == 0) drive_cyc[src] = cyc;
            budget = 300;
            while (budget > 0) begin
                @(negedge clock);
                if (s_tready_w[src]) break;
                budget--;
            end
            if (budget == 0) begin
                check("s_handshake_timeout", 64'd1, 64'd0);
                s_tvalid[src] = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
            crc = crc_beat(crc, d, k);
            if (b == 0) begin
                tdest_q.push_back(e_src);
                first_hs_cyc[src] = cyc;
                if (gap_chk && have_end) check("bubble_gap", 64'(cyc - last_end_cyc), 64'd2);
            end
            if (b == nb - 1) begin
                sb_q.push_back({~crc, e_src, e_tu});
                order_q.push_back(src);
                last_end_cyc = cyc;
                have_end = 1'b1;
                frames_done++;
            end
        end
        s_tvalid[src] = 1'b0;
        s_tlast[src]  = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 400;
        while (budget > 0 && (sb_q.size() != 0 || tdest_q.size() != 0)) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #2;
        sb_q.delete();
        tdest_q.delete();
        @(posedge clock);
        #1;
        aresetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        int         src;
        int         nbeats;
        logic [7:0] klast;
        logic       tuser;
        logic       exp_src;
        logic       exp_tuser;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   base_recs;
        int   found;
        logic [31:0] held_crc;

        vecs[0] = '{1, 3, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{0, 1, 8'h01, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1, 2, 8'h07, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{0, 4, 8'h3F, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1, 1, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{0, 2, 8'h0F, 1'b1, 1'b0, 1'b1};

        aresetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tdata[i] = '0; s_tkeep[i] = '0; s_tlast[i] = 1'b0; s_tuser[i] = 1'b0; s_tvalid[i] = 1'b0;
        end
        mdl_ready = 1'b1; o_axis_tready = 1'b1; res_ready = 1'b1;
        inj_en = 1'b0; inj_valid = 1'b0; inj_user = 1'b0; inj_crc = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_s0_tready", 64'(s0_axis_tready), 64'd0);
        check("rst_s1_tready", 64'(s1_axis_tready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_crc", 64'(res_crc), 64'd0);
        check("rst_res_src", 64'(res_src), 64'd0);
        check("rst_res_tuser", 64'(res_tuser), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        aresetn = 1'b1;
        @(posedge clock);
        #1;

        // Single three-beat frame from s0.
        send_frame(0, 3, 8'h0F, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        check("grant_latency", 64'(first_hs_cyc[0] - drive_cyc[0]), 64'd2);
        wait_drain();
        for (int b = 0; b < 3; b++) begin
            check("m_beat_data", mb_data[b], beat_data(64'h0123_4567_89AB_CDEF, b));
            check("m_beat_keep", 64'(mb_keep[b]), (b == 2) ? 64'h0F : 64'hFF);
        end

        // Table of single-source frames.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].src, vecs[i].nbeats, vecs[i].klast, vecs[i].tuser,
                       64'h1111_0000_0000_0000 * 64'(i + 1), vecs[i].exp_src, vecs[i].exp_tuser);
            wait_drain();
        end

        // Contention from reset: strict alternation with one bubble per frame.
        do_reset();
        order_q.delete();
        have_end = 1'b0;
        gap_chk  = 1'b1;
        fork
            for (int f = 0; f < 5; f++) send_frame(0, 2, 8'hFF, 1'b0, 64'hA000 + 64'(f), 1'b0, 1'b0);
            for (int f = 0; f < 5; f++) send_frame(1, 2, 8'h3F, 1'b1, 64'hB000 + 64'(f), 1'b1, 1'b1);
        join
        gap_chk = 1'b0;
        wait_drain();
        check("cont_frames", 64'(order_q.size()), 64'd10);
        for (int i = 0; i < order_q.size(); i++) check("cont_order", 64'(order_q[i]), 64'(i % 2));

        // ID FIFO full: output side blocked, six one-beat frames.
        o_axis_tready = 1'b0;
        frames_done = 0;
        base_recs = recs_seen;
        fork
            for (int f = 0; f < 3; f++) send_frame(0, 1, 8'hFF, 1'b0, 64'hC000 + 64'(f), 1'b0, 1'b0);
            for (int f = 0; f < 3; f++) send_frame(1, 1, 8'h01, 1'b0, 64'hD000 + 64'(f), 1'b1, 1'b0);
            begin
                repeat (20) @(posedge clock);
                #1;
                check("full_granted", 64'(frames_done), 64'd4);
                check("full_m_tvalid", 64'(m_axis_tvalid), 64'd0);
                check("full_s0_tready", 64'(s0_axis_tready), 64'd0);
                check("full_s1_tready", 64'(s1_axis_tready), 64'd0);
                o_axis_tready = 1'b1;
            end
        join
        wait_drain();
        check("full_records", 64'(recs_seen - base_recs), 64'd6);

        // Result backpressure with two frames completing.
        res_ready = 1'b0;
        base_recs = recs_seen;
        fork
            begin
                send_frame(0, 2, 8'hFF, 1'b0, 64'hE000, 1'b0, 1'b0);
                send_frame(1, 2, 8'h0F, 1'b1, 64'hE100, 1'b1, 1'b1);
            end
            begin
                found = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clock);
                    if (res_valid && c_axis_tvalid && c_axis_tlast) begin
                        found = 1;
                        break;
                    end
                end
                check("bp_stall_seen", 64'(found), 64'd1);
                if (found == 1 && sb_q.size() > 0) begin
                    held_crc = sb_q[0].crc;
                    check("bp_c_tready", 64'(c_axis_tready), 64'd0);
                    check("bp_o_tvalid", 64'(o_axis_tvalid), 64'd0);
                    check("bp_hold_crc", 64'(res_crc), 64'(held_crc));
                    repeat (5) @(negedge clock);
                    check("bp_c_tready_late", 64'(c_axis_tready), 64'd0);
                    check("bp_hold_crc_late", 64'(res_crc), 64'(held_crc));
                    check("bp_hold_src_late", 64'(res_src), 64'd0);
                    @(posedge clock);
                    #1;
                    res_ready = 1'b1;
                    @(posedge clock);
                    #1;
                    res_ready = 1'b0;
                    check("bp_second_loaded", 64'(res_valid), 64'd1);
                    check("bp_second_src", 64'(res_src), 64'd1);
                end
                res_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_records", 64'(recs_seen - base_recs), 64'd2);

        // Return-path tlast with the ID FIFO empty.
        inj_en = 1'b1;
        inj_valid = 1'b1;
        inj_user = 1'b1;
        inj_crc = 32'hDEADBEEF;
        sb_q.push_back({32'hDEADBEEF, 1'b0, 1'b1});
        @(posedge clock);
        #1;
        inj_valid = 1'b0;
        check("err_set", 64'(err_underflow), 64'd1);
        repeat (3) @(posedge clock);
        #1;
        inj_en = 1'b0;
        send_frame(1, 1, 8'hFF, 1'b0, 64'hF000, 1'b1, 1'b0);
        wait_drain();
        check("err_sticky", 64'(err_underflow), 64'd1);

        // Reset during beat 2 of an s1 frame.
        s_tdata[1] = beat_data(64'hF100, 0);
        s_tkeep[1] = 8'hFF;
        s_tlast[1] = 1'b0;
        s_tuser[1] = 1'b0;
        s_tvalid[1] = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (s1_axis_tready) begin
                found = 1;
                break;
            end
        end
        check("rst_mid_beat1", 64'(found), 64'd1);
        @(posedge clock);
        #1;
        tdest_q.push_back(1'b1);
        s_tdata[1] = beat_data(64'hF100, 1);
        @(negedge clock);
        check("rst_mid_busy", 64'(m_axis_tvalid), 64'd1);
        #1;
        aresetn = 1'b0;
        #1;
        check("rstm_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rstm_s0_tready", 64'(s0_axis_tready), 64'd0);
        check("rstm_s1_tready", 64'(s1_axis_tready), 64'd0);
        check("rstm_res_valid", 64'(res_valid), 64'd0);
        check("rstm_res_crc", 64'(res_crc), 64'd0);
        check("rstm_res_src", 64'(res_src), 64'd0);
        check("rstm_err", 64'(err_underflow), 64'd0);
        check("rstm_tdest", 64'(o_axis_tdest), 64'd0);
        s_tvalid[1] = 1'b0;
        sb_q.delete();
        tdest_q.delete();
        @(posedge clock);
        #1;
        aresetn = 1'b1;
        @(posedge clock);
        #1;
        order_q.delete();
        fork
            send_frame(0, 1, 8'hFF, 1'b0, 64'h5000, 1'b0, 1'b0);
            send_frame(1, 1, 8'hFF, 1'b0, 64'h5100, 1'b1, 1'b0);
        join
        wait_drain();
        check("post_rst_first", 64'(order_q.size() > 0 ? order_q[0] : 9), 64'd0);
        check("post_rst_second", 64'(order_q.size() > 1 ? order_q[1] : 9), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
